ok_event_monitor: RTL
=====================

Name: ok_event_monitor

Overview:
- Parametrised event-counting and trigger-out block for the FrontPanel wrapper; generalises the per-signal edge detectors and done counters into N_CH uniform channels.
- Per channel: edge/level counting, sticky flags, overflow flag and a one-cycle trigger pulse.
- A host-requested snapshot freezes all counters coherently into a bank read out through a channel-select mux feeding a WireOut.
- Sits in the weClk domain between WETOP status outputs and the okWireOut/okTriggerOut endpoints.

Parameters:
- N_CH, 8, number of event channels (1..32).
- CNT_W, 32, counter width per channel (8..32).
- SATURATE, 0: 1 = counters hold at all-ones; 0 = counters wrap to 0.
- SYNC_STAGES, 0, synchroniser flops on ev_in (0 = none, 2 or 3 for async sources).

Ports:
- weClk  in  1  block clock (512 kHz).
- rst_we  in  1  reset, asynchronous, active-high.
- ev_in  in  N_CH  raw event inputs.
- edge_mode  in  N_CH  per channel: 1 = count rising edges; 0 = count cycles high.
- snap_req  in  1  one-cycle pulse that captures all counters into the snapshot bank.
- clr_req  in  1  one-cycle pulse that clears the channels selected by clr_mask.
- clr_mask  in  N_CH  channels affected by clr_req.
- rd_sel  in  8  snapshot channel index for readback.
- cnt_rd  out  CNT_W  snapshot value of channel rd_sel.
- trig_out  out  N_CH  one-cycle pulse per rising edge.
- sticky  out  N_CH  latched "edge seen since clear".
- ovf  out  N_CH  latched counter overflow.
- snap_valid  out  1  high once at least one snapshot has been taken.
- snap_seq  out  8  snapshot sequence number.

Behaviour:
- Reset (rst_we high, async): all counters, snapshot bank, synchroniser/edge flops, cnt_rd, trig_out, sticky, ovf, snap_valid and snap_seq are 0.
- Synchronisation: ev_s = ev_in delayed by SYNC_STAGES flops. With SYNC_STAGES=0, ev_s = ev_in combinationally.
- Edge detect:
  - ev_q <= ev_s; rise = ev_s & ~ev_q.
  - Because ev_q resets to 0, an input already high at reset release yields one rise.
- trig_out <= rise (registered, exactly one cycle per edge). With SYNC_STAGES=0, trig_out is high in the cycle after the sampling edge.
- inc[i] = edge_mode[i] ? rise[i] : ev_s[i]. edge_mode is sampled every cycle; changing it mid-run affects only subsequent cycles.
- Counter update, per channel, in priority order:
  1. clr_req & clr_mask[i]: cnt <= inc[i] ? 1 : 0. An event in the clear cycle is never lost.
  2. Otherwise, if inc[i]:
     - cnt < max: cnt + 1.
     - cnt == max: SATURATE=1 holds all-ones, SATURATE=0 wraps to 0.
     - In both cases ovf[i] <= 1.
- sticky[i]:
  - Set by rise[i] in either edge_mode.
  - Cleared by clr_req & clr_mask[i]; a rise in the same cycle wins (stays 1).
- ovf[i]: cleared by clr_req & clr_mask[i]. An overflow cannot coincide with a clear because the clear path loads 0/1.
- Snapshot:
  - On snap_req, snap[i] <= cnt[i] for all i, using the register values before this cycle's update.
  - snap_valid <= 1 (sticky until reset); snap_seq <= snap_seq + 1, wrapping 255 -> 0.
  - snap_req together with clr_req gives read-and-clear: the snapshot holds pre-clear values and the live counters restart.
- Readback:
  - cnt_rd <= (rd_sel < N_CH) ? snap[rd_sel] : 0, registered, 1-cycle latency.
  - The snapshot bank changes only on snap_req; a new snapshot appears on cnt_rd one cycle after the bank updates.
- Reset mid-operation: everything returns to reset values immediately; no partial snapshot is retained.

Test Plan:
1. Edge counting: N_CH=8, SYNC_STAGES=0, edge_mode=0xFF; ch0 toggles 5 high pulses of 3 cycles; snap_req; rd_sel=0 -> cnt_rd=5, trig_out[0] pulses exactly 5 times (1 cycle each), sticky[0]=1, snap_seq=1, snap_valid=1.
2. Level counting: edge_mode[1]=0; ev_in[1] high 7 cycles -> snapshot cnt=7, sticky[1]=1. rd_sel=9 -> cnt_rd=0.
3. Wrap vs saturate: CNT_W=8.
   - SATURATE=0, 257 edges -> cnt=1, ovf=1.
   - SATURATE=1, 257 edges -> cnt=255, ovf=1.
4. Clear collision: cnt[2]=10 and a rise on ch2 in the same cycle as clr_req with clr_mask=0x04 -> cnt[2]=1, sticky[2]=1, ovf[2]=0; ch3 unaffected.
5. Read-and-clear: cnt[0]=42, snap_req + clr_req (mask 0x01) same cycle, no event -> cnt_rd(ch0)=42, live cnt[0]=0; next snapshot (no events) reads 0; snap_seq increments 1 -> 2.
6. Async reset: assert rst_we mid-pulse-train with SYNC_STAGES=2 -> all outputs 0 immediately. ev_in[4] held high through release -> one trig_out[4] pulse 3 cycles after release, cnt[4]=1.

Source files
------------

// File: rtl/ok_event_monitor.sv
// ok_event_monitor: per-channel event counters, sticky/overflow flags and
// trigger pulses, with a coherent snapshot bank read back through a mux.
module ok_event_monitor #(
  parameter int N_CH        = 8,
  parameter int CNT_W       = 32,
  parameter int SATURATE    = 0,
  parameter int SYNC_STAGES = 0
) (
  input  logic             weClk,
  input  logic             rst_we,
  input  logic [N_CH-1:0]  ev_in,
  input  logic [N_CH-1:0]  edge_mode,
  input  logic             snap_req,
  input  logic             clr_req,
  input  logic [N_CH-1:0]  clr_mask,
  input  logic [7:0]       rd_sel,
  output logic [CNT_W-1:0] cnt_rd,
  output logic [N_CH-1:0]  trig_out,
  output logic [N_CH-1:0]  sticky,
  output logic [N_CH-1:0]  ovf,
  output logic             snap_valid,
  output logic [7:0]       snap_seq
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N_CH-1:0]  ev_s;
  logic [N_CH-1:0]  ev_q;
  logic [N_CH-1:0]  rise;
  logic [N_CH-1:0]  inc;
  logic [N_CH-1:0]  clr_hit;
  logic [CNT_W-1:0] cnt  [N_CH];
  logic [CNT_W-1:0] snap [N_CH];
  logic [CNT_W-1:0] rd_val;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign ev_s = ev_in;
    end else begin : g_sync
      logic [N_CH-1:0] sync_q [SYNC_STAGES];
      always_ff @(posedge weClk or posedge rst_we) begin
        if (rst_we) begin
          for (int k = 0; k < SYNC_STAGES; k++)
            sync_q[k] <= '0;
        end else begin
          sync_q[0] <= ev_in;
          for (int k = 1; k < SYNC_STAGES; k++)
            sync_q[k] <= sync_q[k-1];
        end
      end
      assign ev_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign rise    = ev_s & ~ev_q;
  assign inc     = (edge_mode & rise) | (~edge_mode & ev_s);
  assign clr_hit = clr_req ? clr_mask : '0;

  always_ff @(posedge weClk or posedge rst_we) begin
    if (rst_we) begin
      ev_q     <= '0;
      trig_out <= '0;
      sticky   <= '0;
    end else begin
      ev_q     <= ev_s;
      trig_out <= rise;
      sticky   <= (sticky & ~clr_hit) | rise;
    end
  end

  // Clear loads the current-cycle event so nothing is lost on a collision
  always_ff @(posedge weClk or posedge rst_we) begin
    if (rst_we) begin
      ovf <= '0;
      for (int i = 0; i < N_CH; i++)
        cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (clr_hit[i]) begin
          cnt[i] <= inc[i] ? CNT_W'(1) : '0;
          ovf[i] <= 1'b0;
        end else if (inc[i]) begin
          if (cnt[i] == CNT_MAX) begin
            cnt[i] <= (SATURATE != 0) ? CNT_MAX : '0;
            ovf[i] <= 1'b1;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge weClk or posedge rst_we) begin
    if (rst_we) begin
      snap_valid <= 1'b0;
      snap_seq   <= '0;
      for (int i = 0; i < N_CH; i++)
        snap[i] <= '0;
    end else if (snap_req) begin
      snap_valid <= 1'b1;
      snap_seq   <= snap_seq + 8'd1;
      for (int i = 0; i < N_CH; i++)
        snap[i] <= cnt[i];
    end
  end

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < N_CH; i++)
      if (rd_sel == 8'(i))
        rd_val = snap[i];
  end

  always_ff @(posedge weClk or posedge rst_we) begin
    if (rst_we) cnt_rd <= '0;
    else        cnt_rd <= rd_val;
  end

endmodule
